// File: rtl/snake_pkg.sv
// Shared direction encoding used by the direction queue, direction register and renderer.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // Direction the snake starts in after reset or restart.
  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Opposite direction: the encoding places opposites two steps apart, so flip bit 1.
  function automatic dir_t dir_reverse(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO of 2-bit direction commands with flush and tail peek.
module dir_fifo
  import snake_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  dir_t          i_data,
  output dir_t          o_head,
  output dir_t          o_tail,
  output logic [CW-1:0] o_count
);

  dir_t          r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Guard against underflow and overflow even if the caller misbehaves;
  // a full queue still takes a push when an entry leaves in the same cycle.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_empty   = (r_count == '0);
    w_do_pop  = i_pop && !w_empty && !i_flush;
    w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;
  end

  // Storage carries no reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + AW'(1);
      if (w_do_pop)  r_head <= r_head + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_tail  = r_mem[r_tail - AW'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/dir_cmd_queue.sv
// Filters keyboard direction pulses, queues accepted turns and applies one per game step.
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_pulse,
  input  logic          down_pulse,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          move_tick,
  input  logic          clear,
  output logic [1:0]    dir,
  output logic          step,
  output logic          turned,
  output logic [CW-1:0] q_count,
  output logic          overflow
);

  dir_t          r_dir;
  logic          r_step;
  logic          r_turned;
  logic          r_overflow;

  dir_t          w_head;
  dir_t          w_tail;
  logic [CW-1:0] w_count;
  dir_t          w_cand;
  logic          w_cand_valid;
  dir_t          w_ref;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Pick a single candidate when several keys land in one cycle: UP > RIGHT > DOWN > LEFT.
  always_comb begin
    w_cand       = DIR_UP;
    w_cand_valid = 1'b1;
    if (up_pulse)         w_cand = DIR_UP;
    else if (right_pulse) w_cand = DIR_RIGHT;
    else if (down_pulse)  w_cand = DIR_DOWN;
    else if (left_pulse)  w_cand = DIR_LEFT;
    else                  w_cand_valid = 1'b0;
  end

  // Compare against the newest pending turn (pre-pop), or the applied direction when idle;
  // duplicates and reversals are dropped silently, only a full queue raises overflow.
  always_comb begin
    w_ref    = (w_count != '0) ? w_tail : r_dir;
    w_accept = w_cand_valid && !clear
               && (w_cand != w_ref) && (w_cand != dir_reverse(w_ref));
    w_pop    = move_tick && !clear && (w_count != '0);
    w_push   = w_accept && ((w_count != CW'(DEPTH)) || w_pop);
    w_drop   = w_accept && (w_count == CW'(DEPTH)) && !w_pop;
  end

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cand),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count)
  );

  // Applied direction, step/turn strobes and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= DIR_RESET;
      r_step     <= 1'b0;
      r_turned   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_dir      <= DIR_RESET;
      r_step     <= 1'b0;
      r_turned   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_step   <= move_tick;
      r_turned <= w_pop;
      if (w_pop)  r_dir      <= w_head;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign dir      = r_dir;
  assign step     = r_step;
  assign turned   = r_turned;
  assign q_count  = w_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Directed plus randomized checks of dir_cmd_queue against a queue-based reference model.
module tb_dir_cmd_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_pulse = 1'b0, down_pulse = 1'b0, left_pulse = 1'b0, right_pulse = 1'b0;
  logic          move_tick = 1'b0, clear = 1'b0;
  logic [1:0]    dir;
  logic          step, turned, overflow;
  logic [CW-1:0] q_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_q[$];
  int m_dir = 1;
  int m_step = 0, m_turned = 0, m_ovf = 0;

  localparam logic [3:0] P_NONE = 4'b0000, P_UP = 4'b1000, P_RIGHT = 4'b0100,
                         P_DOWN = 4'b0010, P_LEFT = 4'b0001;

  dir_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_pulse(up_pulse), .down_pulse(down_pulse),
    .left_pulse(left_pulse), .right_pulse(right_pulse),
    .move_tick(move_tick), .clear(clear),
    .dir(dir), .step(step), .turned(turned),
    .q_count(q_count), .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dir"},      int'(dir),      m_dir);
    check({tag, ".step"},     int'(step),     m_step);
    check({tag, ".turned"},   int'(turned),   m_turned);
    check({tag, ".q_count"},  int'(q_count),  m_q.size());
    check({tag, ".overflow"}, int'(overflow), m_ovf);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dir = 1; m_step = 0; m_turned = 0; m_ovf = 0;
  endtask

  // Game rules: one key per cycle by priority, no duplicate/reversal of the latest
  // pending heading, one applied turn per tick, full queue drops unless a slot frees.
  task automatic model_edge(input logic [3:0] p, input logic t, input logic c);
    int cand, refd;
    bit popped, was_full;
    if (c) begin
      model_reset();
      return;
    end
    cand = p[3] ? 0 : p[2] ? 1 : p[1] ? 2 : p[0] ? 3 : -1;
    refd = (m_q.size() > 0) ? m_q[$] : m_dir;
    was_full = (m_q.size() == DEPTH);
    popped = t && (m_q.size() > 0);
    if (popped) m_dir = m_q.pop_front();
    if (cand >= 0 && cand != refd && cand != (refd ^ 2)) begin
      if (!was_full || popped) m_q.push_back(cand);
      else m_ovf = 1;
    end
    m_step = int'(t);
    m_turned = int'(popped);
  endtask

  // One clock cycle: drive inputs after the edge, advance model at the edge, check 1ns later.
  task automatic cyc(input string tag, input logic [3:0] p, input logic t, input logic c);
    up_pulse = p[3]; right_pulse = p[2]; down_pulse = p[1]; left_pulse = p[0];
    move_tick = t; clear = c;
    @(posedge clk);
    model_edge(p, t, c);
    #1;
    check_all(tag);
    $display("cyc %-8s p=%b t=%0d c=%0d -> dir=%0d step=%0d turned=%0d cnt=%0d ovf=%0d",
             tag, p, t, c, dir, step, turned, q_count, overflow);
  endtask

  initial begin
    logic [3:0] rp;
    logic       rt, rc;

    // Reset state while rst_n is low
    #15;
    check_all("reset");
    check("reset.dir_const", int'(dir), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single UP then tick
    cyc("up", P_UP, 0, 0);
    check("up.cnt_const", int'(q_count), 1);
    cyc("tick1", P_NONE, 1, 0);
    check("tick1.dir_const", int'(dir), 0);
    cyc("idle", P_NONE, 0, 0);

    // Back to RIGHT via clear; reversal and duplicate rejected
    cyc("clr", P_NONE, 0, 1);
    cyc("rev", P_LEFT, 0, 0);
    cyc("dup", P_RIGHT, 0, 0);
    cyc("tick2", P_NONE, 1, 0);
    check("tick2.turned_const", int'(turned), 0);

    // UP, LEFT, DOWN chain then three ticks
    cyc("u", P_UP, 0, 0);
    cyc("l", P_LEFT, 0, 0);
    cyc("d", P_DOWN, 0, 0);
    for (int i = 0; i < 3; i++) cyc("chain", P_NONE, 1, 0);
    check("chain.dir_const", int'(dir), 2);

    // Fill to DEPTH and overflow
    cyc("clr2", P_NONE, 0, 1);
    cyc("f1", P_UP, 0, 0);
    cyc("f2", P_LEFT, 0, 0);
    cyc("f3", P_DOWN, 0, 0);
    cyc("f4", P_RIGHT, 0, 0);
    cyc("f5", P_UP, 0, 0);
    check("full.ovf_const", int'(overflow), 1);
    // Push and pop while full
    cyc("fullpp", P_UP, 1, 0);
    check("fullpp.cnt_const", int'(q_count), 4);
    for (int i = 0; i < 4; i++) cyc("drain", P_NONE, 1, 0);

    // Simultaneous pulses, then clear
    cyc("clr3", P_NONE, 0, 1);
    cyc("multi", P_UP | P_LEFT, 0, 0);
    cyc("clr4", P_UP, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : P_NONE;
      rt = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 79) == 0);
      cyc("rand", rp, rt, rc);
    end

    // Asynchronous reset mid-queue
    cyc("pre1", P_UP, 0, 0);
    cyc("pre2", P_LEFT, 1, 0);
    cyc("pre3", P_DOWN, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post1", P_NONE, 1, 0);
    cyc("post2", P_NONE, 1, 0);
    for (int i = 0; i < 100; i++) begin
      rp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : P_NONE;
      rt = ($urandom_range(0, 2) == 0);
      cyc("rand2", rp, rt, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
